// File: rtl/regbus_arb_pkg.sv
// rtl/regbus_arb_pkg.sv - shared types and helpers for the RegBus round-robin arbiter
package regbus_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Default RegBus request/response shapes (32-bit address and data)
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } regbus_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } regbus_rsp_t;

  // Modulo-n increment of an initiator index
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/regbus_rr_pick.sv
// rtl/regbus_rr_pick.sv - rotate-priority encoder: first set request at or after prio_i
module regbus_rr_pick
  import regbus_arb_pkg::*;
#(
  parameter int unsigned NumReq = 2,
  parameter int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   prio_i,
  output logic [IdxW-1:0]   gnt_idx_o,
  output logic              any_o
);

  logic [IdxW-1:0] cand;

  // Walk the requests cyclically from prio_i and keep the first hit
  always_comb begin
    gnt_idx_o = '0;
    any_o     = 1'b0;
    cand      = '0;
    for (int unsigned off = 0; off < NumReq; off++) begin
      cand = IdxW'((32'(prio_i) + off) % NumReq);
      if (!any_o && req_i[cand]) begin
        gnt_idx_o = cand;
        any_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regbus_rr_arbiter.sv
// rtl/regbus_rr_arbiter.sv - round-robin sharing of one RegBus target between initiators
module regbus_rr_arbiter
  import regbus_arb_pkg::*;
#(
  parameter int unsigned NumReq        = 2,
  parameter int unsigned TimeoutCycles = 256,
  parameter type         reg_req_t     = regbus_arb_pkg::regbus_req_t,
  parameter type         reg_rsp_t     = regbus_arb_pkg::regbus_rsp_t,
  parameter int unsigned IdxW          = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  reg_req_t        reg_req_i [NumReq],
  output reg_rsp_t        reg_rsp_o [NumReq],
  output reg_req_t        reg_req_o,
  input  reg_rsp_t        reg_rsp_i,
  output logic            busy_o,
  output logic [IdxW-1:0] gnt_idx_o,
  output logic            timeout_o
);

  localparam int unsigned CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

  arb_state_e      state_q, state_d;
  logic [IdxW-1:0] gnt_q, gnt_d;
  logic [IdxW-1:0] prio_q, prio_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [NumReq-1:0] req_valid;
  logic [IdxW-1:0]   pick_idx;
  logic              pick_any;
  logic              wd_hit;
  logic [IdxW-1:0]   prio_next;

  // Gather the valid bits for the priority encoder
  always_comb begin
    for (int unsigned i = 0; i < NumReq; i++) begin
      req_valid[i] = reg_req_i[i].valid;
    end
  end

  regbus_rr_pick #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) i_pick (
    .req_i     (req_valid),
    .prio_i    (prio_q),
    .gnt_idx_o (pick_idx),
    .any_o     (pick_any)
  );

  assign wd_hit    = (TimeoutCycles != 0) && (cnt_q == CntW'(TimeoutCycles - 1));
  assign prio_next = IdxW'(next_idx(32'(gnt_q), NumReq));
  assign gnt_idx_o = gnt_q;
  assign busy_o    = (state_q == BUSY);

  // State, grant, priority pointer and watchdog registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      prio_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic plus request mux and response demux
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    prio_d    = prio_q;
    cnt_d     = cnt_q;
    reg_req_o = '0;
    timeout_o = 1'b0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      reg_rsp_o[i] = '0;
    end

    case (state_q)
      IDLE: begin
        // Stale target responses here are deliberately ignored
        if (pick_any) begin
          gnt_d   = pick_idx;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_d     = cnt_q + CntW'(1);
        reg_req_o = reg_req_i[gnt_q];
        if (!reg_req_i[gnt_q].valid) begin
          // Initiator withdrew its request: drop the transaction without answering
          state_d = IDLE;
          prio_d  = prio_next;
        end else begin
          reg_rsp_o[gnt_q] = reg_rsp_i;
          if (reg_rsp_i.ready) begin
            state_d = IDLE;
            prio_d  = prio_next;
          end else if (wd_hit) begin
            reg_rsp_o[gnt_q]       = '0;
            reg_rsp_o[gnt_q].error = 1'b1;
            reg_rsp_o[gnt_q].ready = 1'b1;
            timeout_o              = 1'b1;
            state_d                = IDLE;
            prio_d                 = prio_next;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_regbus_rr_arbiter.sv
// tb/tb_regbus_rr_arbiter.sv - directed self-checking bench for regbus_rr_arbiter
module tb_regbus_rr_arbiter;
  import regbus_arb_pkg::*;

  logic        clk;
  logic        rst_n;
  regbus_req_t req_i [2];
  regbus_rsp_t rsp_o [2];
  regbus_req_t req_o;
  regbus_rsp_t rsp_i;
  logic        busy;
  logic [0:0]  gnt_idx;
  logic        timeout;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses;

  regbus_rr_arbiter #(
    .NumReq        (2),
    .TimeoutCycles (8),
    .reg_req_t     (regbus_req_t),
    .reg_rsp_t     (regbus_rsp_t)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .reg_req_i (req_i),
    .reg_rsp_o (rsp_o),
    .reg_req_o (req_o),
    .reg_rsp_i (rsp_i),
    .busy_o    (busy),
    .gnt_idx_o (gnt_idx),
    .timeout_o (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    req_i[0] = '0;
    req_i[1] = '0;
    rsp_i    = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();

    // Reset state
    @(negedge clk); #1;
    check("rst_req_o", req_o, '0);
    check("rst_rsp0", rsp_o[0], '0);
    check("rst_rsp1", rsp_o[1], '0);
    check("rst_busy", busy, 0);
    check("rst_timeout", timeout, 0);
    check("rst_gnt", gnt_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single write, target ready in the third BUSY cycle
    @(negedge clk);
    req_i[0] = '{addr: 32'h10, write: 1'b1, wdata: 32'hA5, wstrb: 4'hF, valid: 1'b1};
    #1;
    check("s1_arb_latency", req_o.valid, 0);
    pulses = 0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      rsp_i.ready = (k == 3);
      #1;
      check("s1_busy", busy, 1);
      check("s1_req_valid", req_o.valid, 1);
      if (k == 1) begin
        check("s1_addr", req_o.addr, 32'h10);
        check("s1_wdata", req_o.wdata, 32'hA5);
        check("s1_gnt", gnt_idx, 0);
      end
      if (rsp_o[0].ready) pulses++;
      if (k == 3) check("s1_error", rsp_o[0].error, 0);
    end
    @(negedge clk);
    clear_inputs();
    #1;
    if (rsp_o[0].ready) pulses++;
    check("s1_idle_after", busy, 0);
    check("s1_ready_once", pulses, 1);

    // Contention from reset: order 0,1,0,1 with one IDLE cycle between grants
    clear_inputs();
    req_i[0] = '{addr: 32'h100, write: 1'b1, wdata: 32'h1, wstrb: 4'hF, valid: 1'b1};
    req_i[1] = '{addr: 32'h104, write: 1'b1, wdata: 32'h2, wstrb: 4'hF, valid: 1'b1};
    apply_reset();
    #1;
    check("s2_first_idle", busy, 0);
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      rsp_i.ready = 1'b1;
      #1;
      check("s2_busy", busy, 1);
      check("s2_order", gnt_idx, t % 2);
      check("s2_rsp_granted", rsp_o[t % 2].ready, 1);
      check("s2_rsp_other", rsp_o[1 - (t % 2)], '0);
      @(negedge clk);
      rsp_i.ready = 1'b0;
      #1;
      check("s2_gap", busy, 0);
    end

    // Read passthrough on initiator 1
    clear_inputs();
    req_i[1] = '{addr: 32'h20, write: 1'b0, wdata: 32'h0, wstrb: 4'h0, valid: 1'b1};
    apply_reset();
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      rsp_i = '{rdata: 32'hDEADBEEF, error: 1'b0, ready: (k == 2)};
      #1;
      check("s3_gnt", gnt_idx, 1);
      check("s3_addr", req_o.addr, 32'h20);
      check("s3_write", req_o.write, 0);
      check("s3_rdata", rsp_o[1].rdata, 32'hDEADBEEF);
      check("s3_rsp0_zero", rsp_o[0], '0);
    end
    @(negedge clk);
    clear_inputs();
    #1;
    check("s3_rsp0_after", rsp_o[0], '0);
    check("s3_idle", busy, 0);

    // Watchdog: target never ready, abort on the eighth BUSY cycle
    req_i[0] = '{addr: 32'h30, write: 1'b1, wdata: 32'h7, wstrb: 4'hF, valid: 1'b1};
    apply_reset();
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      rsp_i = '{rdata: 32'h1234, error: 1'b0, ready: 1'b0};
      #1;
      check("s4_busy", busy, 1);
      check("s4_timeout", timeout, (k == 8));
      check("s4_ready", rsp_o[0].ready, (k == 8));
      if (k == 8) begin
        check("s4_error", rsp_o[0].error, 1);
        check("s4_rdata_zero", rsp_o[0].rdata, 0);
      end
    end
    @(negedge clk);
    req_i[0] = '0;
    rsp_i.ready = 1'b1;
    #1;
    check("s4_late_busy", busy, 0);
    check("s4_late_rsp0", rsp_o[0], '0);
    check("s4_late_rsp1", rsp_o[1], '0);
    check("s4_late_timeout", timeout, 0);
    check("s4_late_req_o", req_o, '0);
    @(negedge clk);
    rsp_i = '0;
    #1;
    check("s4_still_idle", busy, 0);

    // Ready on the exact timeout cycle wins
    clear_inputs();
    req_i[0] = '{addr: 32'h40, write: 1'b0, wdata: 32'h0, wstrb: 4'h0, valid: 1'b1};
    apply_reset();
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      rsp_i = '{rdata: 32'h55, error: 1'b0, ready: (k == 8)};
      #1;
      if (k == 8) begin
        check("s5_no_timeout", timeout, 0);
        check("s5_rsp_normal", rsp_o[0], {32'h55, 1'b0, 1'b1});
      end
    end
    @(negedge clk);
    clear_inputs();

    // Valid dropped in BUSY: silent abort, priority still advances
    req_i[0] = '{addr: 32'h50, write: 1'b1, wdata: 32'h9, wstrb: 4'hF, valid: 1'b1};
    apply_reset();
    @(negedge clk);
    req_i[0].valid = 1'b0;
    rsp_i.ready = 1'b0;
    #1;
    check("s5_drop_busy", busy, 1);
    check("s5_drop_req_valid", req_o.valid, 0);
    check("s5_drop_rsp0", rsp_o[0], '0);
    @(negedge clk);
    req_i[0] = '{addr: 32'h60, write: 1'b1, wdata: 32'h1, wstrb: 4'hF, valid: 1'b1};
    req_i[1] = '{addr: 32'h64, write: 1'b1, wdata: 32'h2, wstrb: 4'hF, valid: 1'b1};
    #1;
    check("s5_drop_idle", busy, 0);
    @(negedge clk);
    #1;
    check("s5_prio_adv_busy", busy, 1);
    check("s5_prio_adv_gnt", gnt_idx, 1);

    // Asynchronous reset while BUSY on initiator 1
    rst_n = 1'b0;
    #1;
    check("s6_busy", busy, 0);
    check("s6_req_o", req_o, '0);
    check("s6_rsp0", rsp_o[0], '0);
    check("s6_rsp1", rsp_o[1], '0);
    check("s6_gnt", gnt_idx, 0);
    check("s6_timeout", timeout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("s6_idle_after", busy, 0);
    @(negedge clk);
    #1;
    check("s6_regrant_busy", busy, 1);
    check("s6_regrant_gnt", gnt_idx, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
